// File: rtl/aes_pkg.sv
// aes_pkg: shared AES widths, GF(2^8) doubling helper and MixColumns FSM states
package aes_pkg;
  localparam int AES_STATE_W = 128;
  localparam int AES_COL_W = 32;
  typedef enum logic [1:0] {IDLE, MIX, DONE} mixcol_state_t;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/mix_single_column.sv
// mix_single_column: combinational MixColumns of one 32-bit column, row 0 in the low byte
module mix_single_column
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] col_i,
  output logic [AES_COL_W-1:0] col_o
);
  logic [7:0] a0, a1, a2, a3;
  function automatic logic [7:0] mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction
  assign {a3, a2, a1, a0} = col_i;
  assign col_o = {mul3(a0) ^ a1 ^ a2 ^ xtime(a3),
                  a0 ^ a1 ^ xtime(a2) ^ mul3(a3),
                  a0 ^ xtime(a1) ^ mul3(a2) ^ a3,
                  xtime(a0) ^ mul3(a1) ^ a2 ^ a3};
endmodule

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: iterative AES MixColumns stage with valid/ready on both sides and final-round bypass
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int STATE_W = 128,
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               last_round,
  input  logic [STATE_W-1:0] state_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] state_out,
  output logic               busy
);
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);
  if (STATE_W != AES_STATE_W) begin : g_bad_width
    $error("mix_columns_seq: STATE_W must be 128");
  end
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end
  mixcol_state_t fsm_q, fsm_d;
  logic [1:0] col_q, col_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [AES_COL_W-1:0] mix_in [COLS_PER_CYCLE];
  logic [AES_COL_W-1:0] mix_out [COLS_PER_CYCLE];
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign mix_in[g] = state_q[AES_COL_W*(int'(col_q)+g) +: AES_COL_W];
    mix_single_column u_mix (.col_i(mix_in[g]), .col_o(mix_out[g]));
  end
  // Next state: capture on accept, overwrite the current column group in place while mixing, release on out_ready
  always_comb begin
    fsm_d = fsm_q;
    col_d = col_q;
    state_d = state_q;
    unique case (fsm_q)
      IDLE: if (in_valid) begin
        state_d = state_in;
        col_d = '0;
        fsm_d = last_round ? DONE : MIX;
      end
      MIX: begin
        for (int i = 0; i < COLS_PER_CYCLE; i++)
          state_d[AES_COL_W*(int'(col_q)+i) +: AES_COL_W] = mix_out[i];
        col_d = (col_q == LAST_COL) ? 2'd0 : col_q + STEP;
        fsm_d = (col_q == LAST_COL) ? DONE : MIX;
      end
      DONE: fsm_d = out_ready ? IDLE : DONE;
      default: fsm_d = IDLE;
    endcase
  end
  // State, column counter and working state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
      col_q <= '0;
      state_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      col_q <= col_d;
      state_q <= state_d;
    end
  end
  assign in_ready = fsm_q == IDLE;
  assign out_valid = fsm_q == DONE;
  assign busy = fsm_q != IDLE;
  assign state_out = state_q;
endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: directed checks of mix_columns_seq against FIPS-197 vectors, handshakes and COLS_PER_CYCLE variants
module tb_mix_columns_seq;
  localparam logic [127:0] FIPS_IN  = 128'hc6c6c6c6_01010101_5c220af2_455313db;
  localparam logic [127:0] FIPS_OUT = 128'hc6c6c6c6_01010101_9d58dc9f_bca14d8e;
  localparam logic [127:0] APPB_IN  = 128'he598271e_f11141b8_ae52b4e0_305dbfd4;
  localparam logic [127:0] APPB_OUT = 128'h4c260628_7ad3f848_9a19cbe0_e5816604;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, last_round = 1'b0, out_ready = 1'b0;
  logic [127:0] state_in = '0;
  logic in_ready, out_valid, busy;
  logic [127:0] state_out;
  logic in_valid2 = 1'b0, out_ready2 = 1'b0, in_ready2, out_valid2, busy2;
  logic [127:0] state_out2;
  logic in_valid4 = 1'b0, out_ready4 = 1'b0, in_ready4, out_valid4, busy4;
  logic [127:0] state_out4;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mix_columns_seq #(.STATE_W(128), .COLS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .last_round(last_round),
    .state_in(state_in), .out_valid(out_valid), .out_ready(out_ready), .state_out(state_out), .busy(busy));
  mix_columns_seq #(.STATE_W(128), .COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .last_round(last_round),
    .state_in(state_in), .out_valid(out_valid2), .out_ready(out_ready2), .state_out(state_out2), .busy(busy2));
  mix_columns_seq #(.STATE_W(128), .COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .last_round(last_round),
    .state_in(state_in), .out_valid(out_valid4), .out_ready(out_ready4), .state_out(state_out4), .busy(busy4));

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (state_out !== 128'h0) begin errors++; $display("FAIL reset_state_out: got %h expected 0", state_out); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic run_vec(input logic [127:0] d, input logic lr, input logic [127:0] exp, input int exp_lat, input string name);
    int n;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready: got %b expected 1", name, in_ready); end
    state_in = d;
    last_round = lr;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != exp_lat) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, n, exp_lat); end
    checks++; if (state_out !== exp) begin errors++; $display("FAIL %s_data: got %h expected %h", name, state_out, exp); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_release: got out_valid=%b in_ready=%b expected 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_fips();
    run_vec(FIPS_IN, 1'b0, FIPS_OUT, 4, "fips");
    run_vec(APPB_IN, 1'b0, APPB_OUT, 4, "appb");
  endtask

  task automatic test_bypass();
    run_vec(FIPS_IN, 1'b1, FIPS_IN, 0, "bypass");
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    state_in = FIPS_IN;
    last_round = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    state_in = APPB_IN;
    last_round = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_done: got %b expected 1", out_valid); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (state_out !== FIPS_IN || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold_%0d: got data=%h in_ready=%b out_valid=%b expected %h/0/1", i, state_out, in_ready, out_valid, FIPS_IN);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_next_accept: got busy=%b expected 1", busy); end
    n = 0;
    while (out_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++; if (state_out !== APPB_OUT || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_next_data: got %h valid=%b expected %h", state_out, out_valid, APPB_OUT);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int first, second, n;
    first = -1;
    second = -1;
    @(negedge clk);
    state_in = FIPS_IN;
    last_round = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready === 1'b1 && first < 0) first = i;
      else if (in_ready === 1'b1 && second < 0) second = i;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (second - first != 6) begin errors++; $display("FAIL b2b_interval: got %0d expected 6", second - first); end
    n = 0;
    while (busy !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain: got busy=%b expected 0", busy); end
  endtask

  task automatic test_mid_reset();
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    state_in = APPB_IN;
    last_round = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || state_out !== 128'h0) begin
      errors++; $display("FAIL midrst_clear: got busy=%b out_valid=%b data=%h expected 0/0/0", busy, out_valid, state_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_no_output: got out_valid_seen=%b in_ready=%b expected 0/1", seen, in_ready);
    end
  endtask

  task automatic test_sweep();
    int l2, l4;
    l2 = -1;
    l4 = -1;
    @(negedge clk);
    state_in = FIPS_IN;
    last_round = 1'b0;
    in_valid2 = 1'b1;
    in_valid4 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    in_valid4 = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (out_valid2 === 1'b1 && l2 < 0) l2 = n;
      if (out_valid4 === 1'b1 && l4 < 0) l4 = n;
      @(negedge clk);
    end
    checks++; if (l2 != 2) begin errors++; $display("FAIL sweep2_latency: got %0d expected 2", l2); end
    checks++; if (l4 != 1) begin errors++; $display("FAIL sweep4_latency: got %0d expected 1", l4); end
    checks++; if (state_out2 !== FIPS_OUT) begin errors++; $display("FAIL sweep2_data: got %h expected %h", state_out2, FIPS_OUT); end
    checks++; if (state_out4 !== FIPS_OUT) begin errors++; $display("FAIL sweep4_data: got %h expected %h", state_out4, FIPS_OUT); end
    out_ready2 = 1'b1;
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready2 = 1'b0;
    out_ready4 = 1'b0;
    checks++; if (out_valid2 !== 1'b0 || out_valid4 !== 1'b0) begin
      errors++; $display("FAIL sweep_release: got %b/%b expected 0/0", out_valid2, out_valid4);
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_bypass();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
